// File: rtl/matinv_sched_if.sv
// Requester and inverter signal bundle for the shared matrix-inverter scheduler.
// master = scheduler side, slave = requesters plus inverter.
interface matinv_sched_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int MATRIX_SIZE = 3,
  parameter int NUM_REQ     = 2
);
  localparam int MW = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*MW-1:0] req_matrix;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [MW-1:0]         resp_matrix;
  logic                  resp_singular;
  logic                  resp_timeout;
  logic                  busy;
  logic                  inv_rst;
  logic                  inv_ready;
  logic                  inv_complete;
  logic [MW-1:0]         inv_matrix;
  logic [MW-1:0]         inv_result;
  logic                  inv_singular;

  modport master (
    input  req_valid, req_matrix, resp_ready, inv_ready, inv_complete, inv_result, inv_singular,
    output req_ready, resp_valid, resp_matrix, resp_singular, resp_timeout, busy, inv_rst, inv_matrix
  );

  modport slave (
    output req_valid, req_matrix, resp_ready, inv_ready, inv_complete, inv_result, inv_singular,
    input  req_ready, resp_valid, resp_matrix, resp_singular, resp_timeout, busy, inv_rst, inv_matrix
  );
endinterface

// File: rtl/matinv_sched.sv
// Round-robin scheduler sharing one fixed-point matrix inverter among NUM_REQ
// requesters, with a watchdog that aborts a stuck inversion.
module matinv_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int MATRIX_SIZE = 3,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic           clk,
  input  logic           rst,
  matinv_sched_if.master bus
);
  localparam int MW    = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, RUN, RESP} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   gnt_q;
  logic [WD_W-1:0]    wd_q;
  logic               inv_rst_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [MW-1:0]      inv_matrix_q;
  logic [MW-1:0]      resp_matrix_q;
  logic               resp_singular_q;
  logic               resp_timeout_q;

  logic [IDX_W-1:0]   gnt_idx_d;
  logic [IDX_W-1:0]   cand;
  logic               gnt_found;
  logic [MW-1:0]      sel_matrix;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   rr_next;
  logic               xfer;
  logic               resp_hs;

  // First valid requester at or above rr_q, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    gnt_idx_d = rr_q;
    gnt_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      if (!gnt_found && ((bus.req_valid >> cand) & NUM_REQ'(1)) != '0) begin
        gnt_found = 1'b1;
        gnt_idx_d = cand;
      end
    end
  end

  always_comb begin
    sel_matrix = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_d == IDX_W'(i)) sel_matrix = bus.req_matrix[i*MW +: MW];
    end
  end

  assign xfer        = (state_q == IDLE) && gnt_found;
  assign req_ready_c = xfer ? (NUM_REQ'(1) << gnt_idx_d) : '0;
  assign gnt_onehot  = NUM_REQ'(1) << gnt_q;
  assign resp_hs     = |(bus.resp_ready & gnt_onehot);
  assign rr_next     = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      rr_q            <= '0;
      gnt_q           <= '0;
      wd_q            <= '0;
      inv_rst_q       <= 1'b1;
      busy_q          <= 1'b0;
      resp_valid_q    <= '0;
      inv_matrix_q    <= '0;
      resp_matrix_q   <= '0;
      resp_singular_q <= 1'b0;
      resp_timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            inv_matrix_q <= sel_matrix;
            gnt_q        <= gnt_idx_d;
            busy_q       <= 1'b1;
            state_q      <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (bus.inv_ready) begin
            wd_q      <= '0;
            inv_rst_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          wd_q <= wd_q + 1'b1;
          // A completion in the watchdog's last cycle still delivers the result.
          if (bus.inv_complete) begin
            resp_matrix_q   <= bus.inv_result;
            resp_singular_q <= bus.inv_singular;
            resp_timeout_q  <= 1'b0;
            resp_valid_q    <= gnt_onehot;
            inv_rst_q       <= 1'b1;
            state_q         <= RESP;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            resp_matrix_q   <= '0;
            resp_singular_q <= 1'b0;
            resp_timeout_q  <= 1'b1;
            resp_valid_q    <= gnt_onehot;
            inv_rst_q       <= 1'b1;
            state_q         <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) begin
            rr_q         <= rr_next;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_matrix   = resp_matrix_q;
  assign bus.resp_singular = resp_singular_q;
  assign bus.resp_timeout  = resp_timeout_q;
  assign bus.busy          = busy_q;
  assign bus.inv_rst       = inv_rst_q;
  assign bus.inv_matrix    = inv_matrix_q;
endmodule

// File: tb/tb_matinv_sched.sv
// Bench for matinv_sched: inverter stub with programmable latency, expected
// responses queued at grant time and compared when the response appears.
module tb_matinv_sched;
  localparam int DW = 32;
  localparam int MS = 3;
  localparam int NR = 2;
  localparam int TO = 16;
  localparam int MW = MS * MS * DW;

  typedef struct {
    int            idx;
    logic [MW-1:0] mat;
    logic          sing;
    logic          to;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   model_ptr;
  int   stub_lat;
  logic [7:0]    stub_cnt;
  logic [MW-1:0] key;
  exp_t sb[$];

  matinv_sched_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .NUM_REQ(NR)) bus ();

  matinv_sched #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inverter stub: counts cycles out of reset, completes after stub_lat cycles,
  // returns operand ^ key and flags an all-zero operand as singular.
  always @(posedge clk or negedge rst) begin
    if (!rst)             stub_cnt <= '0;
    else if (bus.inv_rst) stub_cnt <= '0;
    else                  stub_cnt <= stub_cnt + 8'd1;
  end
  assign bus.inv_ready    = 1'b1;
  assign bus.inv_complete = !bus.inv_rst && (int'(stub_cnt) == stub_lat - 1);
  assign bus.inv_result   = bus.inv_matrix ^ key;
  assign bus.inv_singular = (bus.inv_matrix == '0);

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] m = '0;
    for (int r = 0; r < MS; r++) m[(r*MS+r)*DW +: DW] = 32'h0001_0000;
    return m;
  endfunction

  function automatic logic [MW-1:0] pat(input int s);
    logic [MW-1:0] m = '0;
    for (int e = 0; e < MS*MS; e++) m[e*DW +: DW] = 32'(s) * 32'h0100_0193 + 32'(e);
    return m;
  endfunction

  // Offer a job, follow it through WAIT_RDY/RUN, score the response, then
  // apply `hold` cycles of backpressure before accepting it.
  task automatic run_job(input logic [NR-1:0] vmask, input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                         input int exp_g, input int lat, input int hold, input bit drop);
    exp_t          e;
    logic [MW-1:0] mg;
    int            cycles;
    int            exp_lat;
    mg       = (exp_g == 0) ? m0 : m1;
    stub_lat = lat;
    bus.req_matrix = {m1, m0};
    bus.req_valid  = vmask;
    #1;
    check("grant", bus.req_ready, NR'(1) << exp_g);
    e.idx  = exp_g;
    e.to   = (lat > TO);
    e.mat  = e.to ? '0 : (mg ^ key);
    e.sing = !e.to && (mg == '0);
    sb.push_back(e);
    exp_lat = e.to ? TO : lat;

    @(negedge clk);
    if (drop) bus.req_valid = '0;
    check("wait_inv_rst", bus.inv_rst, 1);
    check("wait_req_ready", bus.req_ready, 0);
    check("wait_busy", bus.busy, 1);
    check("inv_matrix", bus.inv_matrix, mg);
    @(negedge clk);
    check("run_inv_rst", bus.inv_rst, 0);

    cycles = 0;
    while (bus.resp_valid == '0 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("resp_latency", cycles, exp_lat);

    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("resp_valid", bus.resp_valid, NR'(1) << e.idx);
      check("resp_matrix", bus.resp_matrix, e.mat);
      check("resp_singular", bus.resp_singular, e.sing);
      check("resp_timeout", bus.resp_timeout, e.to);
      check("resp_inv_rst", bus.inv_rst, 1);
      for (int h = 0; h < hold; h++) begin
        bus.resp_ready = ~(NR'(1) << e.idx);
        @(negedge clk);
        check("hold_valid", bus.resp_valid, NR'(1) << e.idx);
        check("hold_matrix", bus.resp_matrix, e.mat);
        check("hold_timeout", bus.resp_timeout, e.to);
        check("hold_req_ready", bus.req_ready, 0);
        check("hold_rr_ptr", dut.rr_q, model_ptr);
      end
      bus.resp_ready = NR'(1) << e.idx;
      @(negedge clk);
      bus.resp_ready = '0;
      check("idle_busy", bus.busy, 0);
      check("idle_resp_valid", bus.resp_valid, 0);
      model_ptr = (e.idx + 1) % NR;
    end
    bus.req_valid = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    model_ptr = 0;
    stub_lat = 100;
    key = '0;
    rst = 1'b0;
    bus.req_valid  = '0;
    bus.req_matrix = '0;
    bus.resp_ready = '0;
    repeat (2) @(negedge clk);
    check("rst_inv_rst", bus.inv_rst, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_matrix", bus.resp_matrix, 0);
    check("rst_flags", {bus.resp_singular, bus.resp_timeout}, 0);
    check("rst_inv_matrix", bus.inv_matrix, 0);
    check("rst_req_ready", bus.req_ready, 0);
    rst = 1'b1;
    @(negedge clk);

    // Identity through a zero-key stub, then round-robin 0,1,0,1 with both valid.
    run_job(2'b11, ident(), pat(1), 0, 10, 0, 1'b1);
    key = pat(99);
    run_job(2'b11, pat(2), pat(3), 1, 7, 1, 1'b0);
    run_job(2'b11, pat(4), pat(5), 0, 3, 1, 1'b0);
    run_job(2'b11, pat(6), pat(7), 1, 12, 1, 1'b0);
    // Backpressure on requester 1, requester 0 granted right after handshake.
    run_job(2'b10, pat(8), pat(9), 1, 5, 10, 1'b0);
    run_job(2'b11, pat(10), pat(11), 0, 4, 0, 1'b0);
    // Watchdog with wrap-around grant, then complete in the timeout cycle.
    run_job(2'b01, pat(12), pat(13), 0, 17, 2, 1'b0);
    run_job(2'b10, pat(14), pat(15), 1, 16, 0, 1'b0);
    run_job(2'b01, '0, pat(16), 0, 5, 0, 1'b0);

    // Reset five cycles into RUN of a requester-1 job.
    stub_lat = 100;
    bus.req_matrix = {pat(17), pat(18)};
    bus.req_valid  = 2'b10;
    #1;
    check("mid_grant", bus.req_ready, 2'b10);
    repeat (2) @(negedge clk);
    check("mid_run_inv_rst", bus.inv_rst, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_inv_rst", bus.inv_rst, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_resp_matrix", bus.resp_matrix, 0);
    check("mid_rst_inv_matrix", bus.inv_matrix, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    run_job(2'b11, pat(19), pat(20), 0, 6, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/matinv_sched.md
# matinv_sched

Round-robin scheduler that shares one fixed-point matrix inverter (`matinv<N>`) between `NUM_REQ` requesters. It accepts a flattened matrix from one requester at a time and drives the inverter's active-high reset/ready/complete protocol. It returns the inverse plus singular/timeout status to the granted requester and guards the inverter with a watchdog. It sits between the navigation datapath clients and the single inverter instance.

## Interface
- `DATA_WIDTH`, 32: fixed-point element width. Must match the inverter.
- `MATRIX_SIZE`, 3: N for the N×N matrix. MW = MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH.
- `NUM_REQ`, 2: number of requesters. Legal range 1..8.
- `TIMEOUT`, 4096: maximum cycles in RUN before abort. Must be ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester "matrix available".
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_matrix`  in  NUM_REQ*MW  requester i's matrix at `[i*MW+:MW]`. Same element packing as the inverter.
- `resp_valid`  out  NUM_REQ  one-hot result-valid to the granted requester.
- `resp_ready`  in  NUM_REQ  per-requester result accept.
- `resp_matrix`  out  MW  inverse, shared by all requesters.
- `resp_singular`  out  1  inverter flagged singular.
- `resp_timeout`  out  1  watchdog abort; `resp_matrix` is 0 when set.
- `busy`  out  1  state ≠ IDLE.
- `inv_rst`  out  1  active-high reset to the inverter.
- `inv_ready`  in  1  inverter ready.
- `inv_complete`  in  1  inverter done.
- `inv_matrix`  out  MW  operand register to the inverter.
- `inv_result`  in  MW  inverter output.
- `inv_singular`  in  1  inverter singular flag.

## Operation
- States: IDLE, WAIT_RDY, RUN, RESP. Reset enters IDLE.
- Reset values: `inv_rst`=1; `rr_ptr`=0; watchdog count=0. All other outputs and registers are 0: `req_ready`, `resp_valid`, `resp_matrix`, `resp_singular`, `resp_timeout`, `busy`, `inv_matrix`.
- **IDLE**
  - `inv_rst`=1.
  - Grant g is the first index with `req_valid` high, searching from `rr_ptr` upward with wrap-around.
  - `req_ready[g]`=1 combinationally; all other bits are 0. `req_ready` is all-zero outside IDLE.
  - On the transfer: latch `req_matrix[g*MW+:MW]` into `inv_matrix`, store g, then go to WAIT_RDY.
- **WAIT_RDY**
  - `inv_rst`=1.
  - When `inv_ready` is sampled high: clear the watchdog and go to RUN.
  - `inv_complete` is ignored in this state.
- **RUN**
  - `inv_rst`=0. The watchdog increments every cycle.
  - If `inv_complete` is sampled high: capture `inv_result` into `resp_matrix` and `inv_singular` into `resp_singular`; set `resp_timeout`=0; go to RESP.
  - Else, if the watchdog equals TIMEOUT-1: set `resp_matrix`=0, `resp_singular`=0, `resp_timeout`=1; go to RESP.
  - Complete and timeout in the same cycle: complete wins.
- **RESP**
  - `inv_rst`=1 and `resp_valid[g]`=1. `resp_*` are held stable until `resp_ready[g]`.
  - On handshake: `rr_ptr`=(g+1) mod NUM_REQ, `resp_valid`=0, go to IDLE.
  - `resp_ready` on other indices is ignored.
- `inv_matrix` is held constant from load until the next grant.
- `req_valid` dropping in WAIT_RDY/RUN/RESP has no effect; the job proceeds.
- `rst` asserted in any state (including mid-RUN) immediately returns all registers to their reset values. The in-flight job is dropped with no response.

## Timing
- Grant is combinational in IDLE. The transfer completes in the same cycle T.
- WAIT_RDY is active from T+1. With `inv_ready` high at T+1, `inv_rst` falls at T+2 (RUN).
- `inv_complete` sampled at cycle C gives `resp_valid` and captured data from C+1.
- Timeout: RUN entered at cycle S gives `resp_timeout` from S+TIMEOUT.
- Response handshake at R gives IDLE at R+1. The next grant is possible at R+1.
- `inv_rst` is high for ≥2 cycles between jobs (RESP exit plus IDLE/WAIT_RDY).
- Minimum job turnaround = inverter latency + 4 cycles.

## Test plan
- **Single job, identity.** Requester 0 sends a 3×3 identity, BIN_POS=16, with an inverter stub (complete after 20 cycles).
  - Required: `req_ready[0]` in IDLE, `inv_rst` low from T+2.
  - Required: `resp_valid[0]` at C+1 with `resp_matrix` = identity, singular=0, timeout=0.
- **Round-robin fairness.** Both requesters hold `req_valid` across 4 jobs from reset.
  - Required: grants go 0,1,0,1.
  - Required: `rr_ptr` advances only on response handshake.
- **Singular.** All-zero matrix into a real `matinv3`.
  - Required: `resp_singular`=1, `resp_timeout`=0.
- **Watchdog.** Stub never completes, TIMEOUT=16.
  - Required: `resp_timeout`=1 and `resp_matrix`=0 exactly 16 cycles after RUN entry; `inv_rst` returns to 1.
  - Also drive complete and timeout in the same cycle; required: complete wins.
- **Backpressure.** Hold `resp_ready[1]` low for 10 cycles, then raise it.
  - Required: `resp_*` stable and `req_ready`=0 throughout; requester 0 is granted the cycle after the handshake.
- **Reset mid-RUN.** Pull `rst` low 5 cycles into RUN.
  - Required: `inv_rst`=1, `busy`=0, `resp_valid`=0 immediately.
  - Required: after release, a new job completes normally and is granted starting from index 0.
